// File: rtl/dadda_mac_pkg.sv
// Shared definitions for the Dadda multiplier product accumulator.
package dadda_mac_pkg;

  // Width of the product delivered by the 16x16 unsigned Dadda multiplier.
  localparam int PROD_W_DEF = 32;

  // Accumulator control states: summing products, or holding a finished block sum.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Ceiling log2 for sizing counters at elaboration time; clog2(1) is 0.
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dadda_mac_in_reg.sv
// Stage-1 input register: captures one product per cycle and decouples the
// multiplier's combinational path from the accumulator adder. It can hold one
// product while the accumulator is busy presenting a result.
module dadda_mac_in_reg
  import dadda_mac_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod_i,
  input  logic              consume_en,
  output logic              take,
  output logic [PROD_W-1:0] s1_prod
);

  logic s1_valid;
  logic fire_in;

  // The held product is consumed only while the accumulator is summing.
  assign take     = s1_valid & consume_en;
  // A new product fits when the register is empty or is being drained this cycle;
  // an abort cycle never accepts input.
  assign in_ready = !clear_i & (!s1_valid | take);
  assign fire_in  = in_valid & in_ready;

  // Load on accept, empty on consume, discard on abort.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else if (clear_i) begin
      s1_valid <= 1'b0;
    end else if (fire_in) begin
      s1_valid <= 1'b1;
      s1_prod  <= prod_i;
    end else if (take) begin
      s1_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dadda_mac_accum.sv
// Block accumulator for Dadda multiplier products: sums ACC_LEN consecutive
// products into a guard-extended register and presents each block sum on a
// valid/ready output with a per-block sticky overflow flag.
module dadda_mac_accum
  import dadda_mac_pkg::*;
#(
  parameter  int PROD_W     = PROD_W_DEF,
  parameter  int GUARD_BITS = 8,
  parameter  int ACC_LEN    = 16,
  localparam int ACC_W      = PROD_W + GUARD_BITS,
  localparam int CNT_W      = clog2(ACC_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic              ovf;

  logic              take;
  logic [PROD_W-1:0] s1_prod;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  next_acc;
  logic              next_ovf;
  logic              last_prod;

  dadda_mac_in_reg #(
    .PROD_W (PROD_W)
  ) u_in_reg (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .prod_i     (prod_i),
    .consume_en (state == ACCUM),
    .take       (take),
    .s1_prod    (s1_prod)
  );

  assign last_prod = (cnt == CNT_W'(ACC_LEN - 1));

  // Next accumulator value: the first product of a block replaces the old sum,
  // later products add with the carry out of the top bit feeding the sticky flag.
  always_comb begin
    // NOTE: every always_comb output is assigned on every path so no latch is inferred.
    sum_ext  = {1'b0, acc} + (ACC_W + 1)'(s1_prod);
    next_acc = sum_ext[ACC_W-1:0];
    next_ovf = ovf | sum_ext[ACC_W];
    if (cnt == '0) begin
      next_acc = ACC_W'(s1_prod);
      next_ovf = 1'b0;
    end
  end

  // Accumulate products in ACCUM, present and hold the block result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear_i) begin
      // Abort: drop the partial block and any pending result; out_acc/out_ovf keep
      // their last value so the consumer never sees X.
      state     <= ACCUM;
      cnt       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            acc <= next_acc;
            ovf <= next_ovf;
            if (last_prod) begin
              cnt       <= '0;
              state     <= DONE;
              out_acc   <= next_acc;
              out_ovf   <= next_ovf;
              out_valid <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
